// File: rtl/aes128_round_ctrl_if.sv
// Handshake and datapath-strobe bundle between the AES-128 round sequencer
// and its requester, consumer and round datapath.
interface aes128_round_ctrl_if;
  logic       start_valid;
  logic       start_ready;
  logic       flush;
  logic       ld_init;
  logic       rnd_en;
  logic       key_en;
  logic       final_rnd;
  logic [1:0] col_sel;
  logic [3:0] round_idx;
  logic [7:0] rcon;
  logic       out_valid;
  logic       out_ready;
  logic       busy;

  modport master (
    input  start_valid, flush, out_ready,
    output start_ready, ld_init, rnd_en, key_en, final_rnd,
           col_sel, round_idx, rcon, out_valid, busy
  );

  modport slave (
    output start_valid, flush, out_ready,
    input  start_ready, ld_init, rnd_en, key_en, final_rnd,
           col_sel, round_idx, rcon, out_valid, busy
  );
endinterface

// File: rtl/aes128_round_ctrl.sv
// Iterative AES-128 encryption sequencer: strobes the shared round datapath
// and key expander through the initial key add and rounds 1..10.
//
// state | meaning
// IDLE  | waiting for a start request
// INIT  | one cycle: state <= pt ^ key, round key <= key
// ROUND | rounds 1..10, CYCLES_PER_ROUND sub-cycles each
// DONE  | ciphertext held valid until the consumer takes it
module aes128_round_ctrl #(
  parameter int CYCLES_PER_ROUND = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  aes128_round_ctrl_if.master  bus
);

  typedef enum logic [1:0] {IDLE, INIT, ROUND, DONE} state_t;

  localparam logic [1:0] SUB_LAST  = 2'(CYCLES_PER_ROUND - 1);
  localparam logic [3:0] LAST_RND  = 4'd10;

  state_t     state, state_nxt;
  logic [3:0] round_q, round_nxt;
  logic [1:0] sub_cnt, sub_nxt;
  logic       sub_last;

  assign sub_last = (sub_cnt >= SUB_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      round_q <= 4'd0;
      sub_cnt <= 2'd0;
    end else begin
      state   <= state_nxt;
      round_q <= round_nxt;
      sub_cnt <= sub_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    round_nxt = round_q;
    sub_nxt   = sub_cnt;
    case (state)
      IDLE: begin
        if (bus.start_valid) begin
          state_nxt = INIT;
          round_nxt = 4'd0;
          sub_nxt   = 2'd0;
        end
      end
      INIT: begin
        state_nxt = ROUND;
        round_nxt = 4'd1;
        sub_nxt   = 2'd0;
      end
      ROUND: begin
        if (sub_last) begin
          sub_nxt = 2'd0;
          if (round_q >= LAST_RND) begin
            state_nxt = DONE;
            round_nxt = 4'd0;
          end else begin
            round_nxt = round_q + 4'd1;
          end
        end else begin
          sub_nxt = sub_cnt + 2'd1;
        end
      end
      DONE: begin
        // A start arriving with the hand-off goes straight to INIT.
        if (bus.out_ready) begin
          state_nxt = bus.start_valid ? INIT : IDLE;
          round_nxt = 4'd0;
          sub_nxt   = 2'd0;
        end
      end
      default: begin
        state_nxt = IDLE;
        round_nxt = 4'd0;
        sub_nxt   = 2'd0;
      end
    endcase
    if (bus.flush) begin
      state_nxt = IDLE;
      round_nxt = 4'd0;
      sub_nxt   = 2'd0;
    end
  end

  logic adv;
  assign adv = (state == ROUND) && sub_last && !bus.flush;

  assign bus.ld_init     = (state == INIT);
  assign bus.rnd_en      = adv;
  assign bus.key_en      = adv;
  assign bus.final_rnd   = (state == ROUND) && (round_q == LAST_RND);
  assign bus.col_sel     = (state == ROUND) ? sub_cnt : 2'd0;
  assign bus.round_idx   = round_q;
  assign bus.out_valid   = (state == DONE);
  assign bus.busy        = (state == INIT) || (state == ROUND);
  assign bus.start_ready = (state == IDLE) || ((state == DONE) && bus.out_ready);

  always_comb begin
    bus.rcon = 8'h00;
    case (round_q)
      4'd1:    bus.rcon = 8'h01;
      4'd2:    bus.rcon = 8'h02;
      4'd3:    bus.rcon = 8'h04;
      4'd4:    bus.rcon = 8'h08;
      4'd5:    bus.rcon = 8'h10;
      4'd6:    bus.rcon = 8'h20;
      4'd7:    bus.rcon = 8'h40;
      4'd8:    bus.rcon = 8'h80;
      4'd9:    bus.rcon = 8'h1b;
      4'd10:   bus.rcon = 8'h36;
      default: bus.rcon = 8'h00;
    endcase
  end

endmodule

// File: doc/aes128_round_ctrl.md
Name: aes128_round_ctrl

Overview:
- Iterative AES-128 encryption sequencer: drives the control strobes for the shared round datapath (sub_bytes -> shift_rows -> mix_columns -> add_round_key) and the on-the-fly key expansion.
- Accepts a start request, loads the initial AddRoundKey, runs rounds 1..10 with mix_columns bypassed in round 10, then presents a result-valid handshake.
- Sits between the top-level block interface and the datapath registers. Owns no 128-bit data, only sequencing.

Parameters:
- CYCLES_PER_ROUND, 1, datapath cycles per round (legal 1..4; 4 = column-serial S-box sharing).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start_valid  in  1  requester has plaintext/key on the datapath inputs.
- start_ready  out  1  controller can accept a start this cycle.
- flush  in  1  synchronous abort, back to IDLE.
- ld_init  out  1  datapath: state <= pt ^ key, round key <= key.
- rnd_en  out  1  datapath: state <= round output.
- key_en  out  1  key expander: advance to next round key.
- final_rnd  out  1  round 10: mix_columns bypassed.
- col_sel  out  2  column being processed within a round (0 when CYCLES_PER_ROUND=1).
- round_idx  out  4  current round number, 0..10.
- rcon  out  8  round constant for key expansion of round_idx.
- out_valid  out  1  ciphertext valid on the datapath state register.
- out_ready  in  1  consumer takes the ciphertext.
- busy  out  1  high in INIT or ROUND.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Reset state: state=IDLE, round_idx=0, sub_cnt=0.
- Output values in reset: all strobes 0, out_valid=0, busy=0, rcon=0, col_sel=0, start_ready=1.
- Outputs are Moore-decoded from state, round_idx and sub_cnt. Exception: start_ready also depends on out_ready.
- IDLE:
  - start_ready=1.
  - start_valid & start_ready -> INIT.
- INIT (1 cycle):
  - ld_init=1, round_idx=0.
  - Next state ROUND with round_idx=1, sub_cnt=0.
- ROUND:
  - sub_cnt counts 0..CYCLES_PER_ROUND-1; col_sel=sub_cnt.
  - rnd_en=1 and key_en=1 only when sub_cnt==CYCLES_PER_ROUND-1. At that point sub_cnt wraps to 0 and round_idx increments.
  - final_rnd=1 for every cycle with round_idx==10.
  - On the last cycle of round 10 -> DONE, round_idx returns to 0.
- rcon is a function of round_idx:
  - 1..10 -> 01,02,04,08,10,20,40,80,1B,36 (hex).
  - 0 -> 00.
- DONE:
  - out_valid=1, held until out_ready=1.
  - out_valid & out_ready with start_valid=0 -> IDLE.
  - Back-to-back: in DONE, start_ready=out_ready. out_ready & start_valid in the same cycle -> INIT directly, with no IDLE bubble.
- Latency: start accepted at edge E.
  - ld_init in cycle E+1.
  - Last rnd_en in cycle E+1+10*CYCLES_PER_ROUND.
  - out_valid from cycle E+2+10*CYCLES_PER_ROUND (E+12 for CYCLES_PER_ROUND=1).
- Throughput: one block per 2+10*CYCLES_PER_ROUND cycles with out_ready tied high and back-to-back starts.
- flush:
  - Highest priority; takes effect at the next edge from any state.
  - Returns to IDLE, round_idx=0, sub_cnt=0; no rnd_en/key_en that cycle.
  - flush with start_valid in IDLE: start not accepted. start_ready reads 1 but flush wins.
- Counters never wrap past 10 / CYCLES_PER_ROUND-1. An illegal state decodes to IDLE on the next edge.
- Reset asserted mid-operation: immediate return to reset values; no partial out_valid.

Test Plan:
- CYCLES_PER_ROUND=1, out_ready=1, one start:
  - ld_init at E+1.
  - rnd_en for 10 consecutive cycles with rcon 01,02,04,08,10,20,40,80,1B,36.
  - final_rnd only on the 10th.
  - out_valid exactly 1 cycle at E+12.
  - Datapath model yields FIPS-197 C.1 ciphertext 69C4E0D86A7B0430D8CDB78070B4C55A.
- CYCLES_PER_ROUND=4:
  - col_sel cycles 0,1,2,3 per round; rnd_en/key_en only at col_sel=3 (10 pulses total).
  - out_valid at E+42.
- Backpressure: out_ready=0 for 5 cycles in DONE.
  - out_valid held, start_ready=0, start_valid ignored.
  - Release with start_valid=1 -> INIT next cycle (no IDLE cycle).
- Back-to-back: start_valid and out_ready held high for 3 blocks.
  - ld_init pulses exactly 12 cycles apart (CYCLES_PER_ROUND=1).
  - 3 out_valid pulses.
- flush at round_idx=5:
  - Next cycle IDLE, busy=0, no further rnd_en, out_valid never asserted.
  - A new start then completes normally.
- rst_n low at round_idx=7:
  - Outputs at reset values immediately (asynchronously).
  - After release, start_ready=1 and a full run is correct.
